// File: rtl/wb_uart_master_if.sv
// Byte-stream and Wishbone B3 signal bundle for wb_uart_master.
// The master modport is the bridge itself; slave is the side driving its inputs.
interface wb_uart_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        ack_i;
  logic [31:0] dat_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, ack_i, dat_i,
    output tx_data, tx_valid, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ack_i, dat_i,
    input  tx_data, tx_valid, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );
endinterface

// File: rtl/wb_uart_master.sv
// Serial-command Wishbone B3 classic initiator ('W' addr data -> 'K', 'R' addr -> 4 data bytes).
// Optional bus watchdog enabled by defining WB_UART_MASTER_TIMEOUT_EN (replies 'E' on expiry).
module wb_uart_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_uart_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        stb_q, stb_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] resp_q, resp_d;
  logic        err_q, err_d;
  logic        bus_timeout;

`ifdef WB_UART_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts ack-less BUS cycles; the cycle that would make the count TIMEOUT aborts.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != BUS) to_cnt_d = '0;
    else if (!bus.ack_i) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign bus_timeout = (state_q == BUS) && !bus.ack_i && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  // TIMEOUT has no effect when the watchdog is compiled out.
  assign bus_timeout = 1'b0 & (TIMEOUT != 0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    stb_d      = stb_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    resp_d     = resp_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == 8'h57 || bus.rx_data == 8'h52)) begin
          we_d    = (bus.rx_data == 8'h57);
          cnt_d   = 2'd0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus.rx_valid) begin
          adr_d = {adr_q[23:0], bus.rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              stb_d   = 1'b1;
              sel_d   = 4'hF;
            end
          end
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          dat_d = {dat_q[23:0], bus.rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = BUS;
            stb_d   = 1'b1;
            sel_d   = 4'hF;
          end
        end
      end
      BUS: begin
        // An ack in the expiry cycle wins over the watchdog.
        if (bus.ack_i) begin
          stb_d      = 1'b0;
          sel_d      = 4'h0;
          state_d    = RESP;
          cnt_d      = 2'd0;
          err_d      = 1'b0;
          resp_d     = bus.dat_i;
          tx_valid_d = 1'b1;
          tx_data_d  = we_q ? 8'h4B : bus.dat_i[31:24];
        end else if (bus_timeout) begin
          stb_d      = 1'b0;
          sel_d      = 4'h0;
          state_d    = RESP;
          cnt_d      = 2'd0;
          err_d      = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h45;
        end
      end
      RESP: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (we_q || err_q || cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            cnt_d     = cnt_q + 2'd1;
            resp_d    = {resp_q[23:0], 8'h00};
            tx_data_d = resp_q[23:16];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      we_q       <= 1'b0;
      adr_q      <= 32'h0;
      dat_q      <= 32'h0;
      stb_q      <= 1'b0;
      sel_q      <= 4'h0;
      tx_data_q  <= 8'h0;
      tx_valid_q <= 1'b0;
      resp_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      stb_q      <= stb_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
    end
  end

  assign bus.cyc_o    = stb_q;
  assign bus.stb_o    = stb_q;
  assign bus.we_o     = we_q;
  assign bus.adr_o    = adr_q;
  assign bus.dat_o    = dat_q;
  assign bus.sel_o    = sel_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master: write/read commands, garbage bytes, mid-bus reset, watchdog.
// Watchdog cases run only when WB_UART_MASTER_TIMEOUT_EN is defined (bench uses TIMEOUT=16).
module tb_wb_uart_master;

  logic clk;
  logic rst_n;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  wb_uart_master_if bus_if ();

  wb_uart_master #(.TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic sendWrite(input logic [31:0] adr, input logic [31:0] dat);
    applyStimulus(8'h57);
    for (int i = 3; i >= 0; i--) applyStimulus(adr[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) applyStimulus(dat[i*8 +: 8]);
  endtask

  task automatic sendRead(input logic [31:0] adr);
    applyStimulus(8'h52);
    for (int i = 3; i >= 0; i--) applyStimulus(adr[i*8 +: 8]);
  endtask

  // Called at the negedge in bus cycle 1; acks during cycle n.
  task automatic ackOnCycle(input int n, input logic [31:0] rdata);
    repeat (n - 1) @(negedge clk);
    bus_if.ack_i = 1'b1;
    bus_if.dat_i = rdata;
    @(negedge clk);
    bus_if.ack_i = 1'b0;
    checkOutput("stb_drop_after_ack", {31'h0, bus_if.stb_o}, 32'h0);
    checkOutput("tx_valid_after_ack", {31'h0, bus_if.tx_valid}, 32'h1);
  endtask

  task automatic receiveByte(input string tag, input logic [7:0] exp, input int stall);
    int waited = 0;
    while (!bus_if.tx_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_valid"}, {31'h0, bus_if.tx_valid}, 32'h1);
    checkOutput({tag, "_data"}, {24'h0, bus_if.tx_data}, {24'h0, exp});
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      checkOutput({tag, "_held"}, {24'h0, bus_if.tx_data}, {24'h0, exp});
    end
    bus_if.tx_ready = 1'b1;
    @(negedge clk);
    bus_if.tx_ready = 1'b0;
  endtask

  task automatic checkBusStart(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic chk_dat);
    checkOutput({tag, "_stb"}, {31'h0, bus_if.stb_o}, 32'h1);
    checkOutput({tag, "_cyc"}, {31'h0, bus_if.cyc_o}, 32'h1);
    checkOutput({tag, "_we"},  {31'h0, bus_if.we_o}, {31'h0, we});
    checkOutput({tag, "_sel"}, {28'h0, bus_if.sel_o}, 32'hF);
    checkOutput({tag, "_adr"}, bus_if.adr_o, adr);
    if (chk_dat) checkOutput({tag, "_dat"}, bus_if.dat_o, dat);
  endtask

  // Wishbone/tx-hold monitor sampling just after each rising edge.
  logic        mon_ack, mon_rdy, mon_rst;
  logic        prev_stb = 1'b0, prev_we = 1'b0, prev_txv = 1'b0;
  logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0;
  logic [3:0]  prev_sel = 4'h0;
  logic [7:0]  prev_txd = 8'h0;

  always @(posedge clk) begin
    mon_ack = bus_if.ack_i;
    mon_rdy = bus_if.tx_ready;
    mon_rst = rst_n;
    #1;
    if (bus_if.stb_o && !bus_if.cyc_o) checkOutput("stb_implies_cyc", {31'h0, bus_if.cyc_o}, 32'h1);
    if (mon_rst && prev_stb && !mon_ack && bus_if.stb_o) begin
      checkOutput("hold_adr", bus_if.adr_o, prev_adr);
      checkOutput("hold_dat", bus_if.dat_o, prev_dat);
      checkOutput("hold_sel", {28'h0, bus_if.sel_o}, {28'h0, prev_sel});
      checkOutput("hold_we",  {31'h0, bus_if.we_o}, {31'h0, prev_we});
    end
    if (mon_rst && prev_txv && !mon_rdy) begin
      checkOutput("hold_tx_valid", {31'h0, bus_if.tx_valid}, 32'h1);
      checkOutput("hold_tx_data", {24'h0, bus_if.tx_data}, {24'h0, prev_txd});
    end
    prev_stb = bus_if.stb_o;
    prev_adr = bus_if.adr_o;
    prev_dat = bus_if.dat_o;
    prev_sel = bus_if.sel_o;
    prev_we  = bus_if.we_o;
    prev_txv = bus_if.tx_valid;
    prev_txd = bus_if.tx_data;
  end

  initial begin
    rst_n           = 1'b0;
    bus_if.rx_data  = 8'h0;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_if.ack_i    = 1'b0;
    bus_if.dat_i    = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
    checkOutput("rst_stb", {31'h0, bus_if.stb_o}, 32'h0);
    checkOutput("rst_we", {31'h0, bus_if.we_o}, 32'h0);
    checkOutput("rst_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
    checkOutput("rst_adr", bus_if.adr_o, 32'h0);
    checkOutput("rst_dat", bus_if.dat_o, 32'h0);
    checkOutput("rst_sel", {28'h0, bus_if.sel_o}, 32'h0);
    checkOutput("rst_tx_data", {24'h0, bus_if.tx_data}, 32'h0);
    rst_n = 1'b1;

    // Write with a 3-cycle ack, 'K' reply.
    sendWrite(32'h1000_0004, 32'hDEAD_BEEF);
    checkBusStart("wr", 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1);
    ackOnCycle(3, 32'h0);
    receiveByte("wr_k", 8'h4B, 0);
    checkOutput("wr_done_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);

    // Read with a slow sink.
    sendRead(32'h0000_0008);
    checkBusStart("rd", 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    ackOnCycle(1, 32'h1234_5678);
    receiveByte("rd_b0", 8'h12, 5);
    receiveByte("rd_b1", 8'h34, 5);
    receiveByte("rd_b2", 8'h56, 5);
    receiveByte("rd_b3", 8'h78, 5);
    checkOutput("rd_done_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);

    // Garbage before a read, stray bytes during BUS and RESP.
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("garbage_idle_stb", {31'h0, bus_if.stb_o}, 32'h0);
    sendRead(32'h0000_0020);
    checkBusStart("gb", 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    applyStimulus(8'h57);
    ackOnCycle(1, 32'hA5A5_0F0F);
    applyStimulus(8'h52);
    receiveByte("gb_b0", 8'hA5, 0);
    receiveByte("gb_b1", 8'hA5, 0);
    receiveByte("gb_b2", 8'h0F, 0);
    receiveByte("gb_b3", 8'h0F, 0);
    checkOutput("gb_done_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
    sendWrite(32'h0000_0040, 32'hCAFE_F00D);
    checkBusStart("after_gb", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b1);
    ackOnCycle(2, 32'h0);
    receiveByte("after_gb_k", 8'h4B, 0);

    // Reset while the bus cycle is outstanding.
    sendRead(32'h0000_0100);
    checkBusStart("mr", 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mr_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
    checkOutput("mr_stb", {31'h0, bus_if.stb_o}, 32'h0);
    checkOutput("mr_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
    rst_n = 1'b1;
    bus_if.ack_i = 1'b1;
    @(negedge clk);
    bus_if.ack_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mr_no_tx", {31'h0, bus_if.tx_valid}, 32'h0);
    sendWrite(32'h0000_0200, 32'h0102_0304);
    checkBusStart("mr_next", 1'b1, 32'h0000_0200, 32'h0102_0304, 1'b1);
    ackOnCycle(1, 32'h0);
    receiveByte("mr_next_k", 8'h4B, 0);

`ifdef WB_UART_MASTER_TIMEOUT_EN
    begin
      int stb_cycles = 0;
      sendRead(32'h0000_0300);
      while (bus_if.stb_o && stb_cycles < 40) begin
        stb_cycles++;
        @(negedge clk);
      end
      checkOutput("to_stb_cycles", stb_cycles, 32'd16);
      receiveByte("to_e", 8'h45, 0);
      checkOutput("to_done_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
    end
    sendWrite(32'h0000_0304, 32'h5555_AAAA);
    checkBusStart("to_ack16", 1'b1, 32'h0000_0304, 32'h5555_AAAA, 1'b1);
    ackOnCycle(16, 32'h0);
    receiveByte("to_ack16_k", 8'h4B, 0);
    sendRead(32'h0000_0308);
    ackOnCycle(16, 32'h8765_4321);
    receiveByte("to_rd_b0", 8'h87, 0);
    receiveByte("to_rd_b1", 8'h65, 0);
    receiveByte("to_rd_b2", 8'h43, 0);
    receiveByte("to_rd_b3", 8'h21, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/wb_uart_master.md
Name: wb_uart_master

Overview:
- Wishbone B3 classic initiator driven by a byte-serial command stream: the debug/host end of the bus, opposite to the UART slave peripheral.
- Byte input comes from a uart_rx-style source (valid pulse, no backpressure); byte output goes to a uart_tx-style sink (valid/ready).
- Host loads and inspects memory and peripherals over the serial link without the CPU.
- Sits between uart_rx/uart_tx instances and the SoC interconnect as an extra bus master.

Parameters:
- TIMEOUT, 1024: bus cycles to wait for ack_i before aborting. Used only with WB_UART_MASTER_TIMEOUT_EN.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; synchronous, active-low
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts tx_data this cycle
- cyc_o  output  1  Wishbone cycle
- stb_o  output  1  Wishbone strobe
- we_o  output  1  Wishbone write enable
- adr_o  output  32  Wishbone byte address
- dat_o  output  32  Wishbone write data
- sel_o  output  4  byte selects; always 4'hF while stb_o=1
- ack_i  input  1  Wishbone acknowledge
- dat_i  input  32  Wishbone read data

Behaviour:
- Reset (rst_i=0 at a clk_i edge) forces state IDLE and clears the byte counter.
- Outputs in reset: cyc_o=0, stb_o=0, we_o=0, tx_valid=0, adr_o=0, dat_o=0, sel_o=0, tx_data=0.
- Reset asserted mid-bus-cycle or mid-response drops cyc_o/stb_o/tx_valid on that edge. No response is sent.

Command framing (all multi-byte fields MSB first):
- Write: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0.
- Read: 0x52 'R', A3 A2 A1 A0.

FSM states IDLE, ADDR, DATA, BUS, RESP:
- IDLE: on rx_valid, byte 0x57 sets we_o=1 and byte 0x52 sets we_o=0; either goes to ADDR with cnt=0. Any other byte is discarded and the FSM stays in IDLE.
- ADDR: each rx_valid shifts rx_data into adr_o from the LSB side (adr_o <= {adr_o[23:0], rx_data}); cnt increments.
  - On the 4th byte: write goes to DATA (cnt=0); read goes to BUS.
- DATA: same shift into dat_o; the 4th byte goes to BUS.
- BUS: cyc_o=stb_o=1 and sel_o=4'hF from the first BUS cycle.
  - adr_o, dat_o and we_o are held stable while stb_o=1.
  - First cycle with ack_i=1: capture dat_i into the response shift register (reads); deassert cyc_o/stb_o on the next edge; go to RESP with cnt=0.
  - Exactly one ack is consumed per command. There are no back-to-back cycles.
- RESP, write: tx_data=0x4B 'K', tx_valid=1 until the tx_valid & tx_ready edge, then IDLE.
- RESP, read: send 4 bytes, MSB first.
  - Each tx_valid & tx_ready edge advances to the next byte.
  - tx_valid stays high between bytes while the sink is ready.
  - After byte 4 is accepted: tx_valid=0, go to IDLE.
- tx_data/tx_valid are registered and must not change while tx_valid=1 and tx_ready=0.
- rx_valid bytes arriving in BUS or RESP are dropped. No buffering.
- Latency: last command byte strobe -> stb_o high on the next cycle.
- Latency: ack_i sampled -> tx_valid high one cycle later.
- ack_i outside BUS is ignored.

Optional Feature:
Macro WB_UART_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments every BUS cycle without ack_i.
  - When it reaches TIMEOUT, cyc_o/stb_o drop on the next edge and the FSM enters RESP in error mode.
  - Error mode sends the single byte 0x45 'E' for both reads and writes, then returns to IDLE.
  - ack_i arriving in the same cycle the count hits TIMEOUT takes priority: normal completion.
- Undefined: no counter logic; BUS waits for ack_i indefinitely.

Test Plan:
- Write: rx bytes 57 10 00 00 04 DE AD BE EF -> one cycle with adr_o=0x10000004, dat_o=0xDEADBEEF, we_o=1, sel_o=F. Ack after 3 cycles -> tx byte 4B, then IDLE.
- Read: rx 52 00 00 00 08, slave returns dat_i=0x12345678 -> we_o=0 cycle at 0x00000008; tx bytes 12 34 56 78 in order. With tx_ready low 5 cycles per byte, tx_data stays stable.
- Garbage/overlap: rx 00 FF 52 then address bytes -> the first two bytes are ignored and the read executes. Extra rx bytes sent during BUS/RESP are dropped, and the next command still parses correctly.
- Reset mid-BUS: drive rst_i=0 while stb_o=1 and ack_i=0 -> cyc_o/stb_o=0 after the edge, no tx byte, and the next command works normally.
- Timeout (macro defined, TIMEOUT=16): no ack_i -> stb_o high exactly 16 cycles, then tx byte 45. Second run with ack_i on cycle 16 -> normal 'K'/data response.
- Wishbone compliance: throughout all tests assert stb_o implies cyc_o, and check that sel_o, adr_o and dat_o never change while stb_o=1 and ack_i=0.
